pmod_max_sonar_pw_meter: RTL

- Measurement core that sits directly upstream of the Pmod MaxSonar AXI4-Lite register file.
- Drives the sensor RX (ranging enable) pin and times the sensor PW pulse (147 us per inch).
- Converts the pulse to whole inches and presents distance, raw pulse width, status and a sample counter for the register file to capture.

---
 rtl/pmod_max_sonar_pw_meter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pmod_max_sonar_pw_meter.sv
// MaxSonar PW pulse timer: times the PW high pulse in us and in whole inches (147 us/inch).
// PW is synchronized (2 FF + edge register); results update with a one-cycle dist_valid strobe.
module pmod_max_sonar_pw_meter #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int US_PER_INCH = 147,
    parameter int TIMEOUT_US  = 40000,
    parameter int DIST_WIDTH  = 9
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  enable,
    input  logic                  pw_in,
    output logic                  sonar_rx,
    output logic [DIST_WIDTH-1:0] distance_in,
    output logic [15:0]           pulse_us,
    output logic                  dist_valid,
    output logic                  timeout,
    output logic                  busy,
    output logic [15:0]           meas_count
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1000000;
    localparam int PW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int SW = (US_PER_INCH > 1) ? $clog2(US_PER_INCH) : 1;

    localparam logic [PW-1:0]         PRESC_MAX = PW'(CYC_PER_US - 1);
    localparam logic [SW-1:0]         SUB_MAX   = SW'(US_PER_INCH - 1);
    localparam logic [15:0]           US_MAX    = 16'(TIMEOUT_US);
    localparam logic [DIST_WIDTH-1:0] INCH_MAX  = '1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ARM       = 2'd1;
    localparam logic [1:0] S_WAIT_RISE = 2'd2;
    localparam logic [1:0] S_MEASURE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  pw_s1_q, pw_s2_q, pw_d_q;
    logic [PW-1:0]         presc_q, presc_d;
    logic [15:0]           us_q, us_d;
    logic [SW-1:0]         sub_q, sub_d;
    logic [DIST_WIDTH-1:0] inch_q, inch_d;
    logic [DIST_WIDTH-1:0] dist_q, dist_d;
    logic [15:0]           pulse_q, pulse_d;
    logic                  valid_q, valid_d;
    logic                  tmo_q, tmo_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  rx_q, rx_d;
    logic                  busy_q, busy_d;

    logic                  pw_rise, pw_fall, us_tick, inch_tick;
    logic [PW-1:0]         presc_nxt;
    logic [15:0]           us_nxt;
    logic [SW-1:0]         sub_nxt;
    logic [DIST_WIDTH-1:0] inch_nxt;

    assign pw_rise   = pw_s2_q & ~pw_d_q;
    assign pw_fall   = ~pw_s2_q & pw_d_q;
    assign us_tick   = (presc_q == PRESC_MAX);
    assign inch_tick = us_tick && (sub_q == SUB_MAX);
    assign presc_nxt = us_tick ? '0 : presc_q + 1'b1;
    assign us_nxt    = (us_tick && us_q != US_MAX) ? us_q + 16'd1 : us_q;
    assign sub_nxt   = inch_tick ? '0 : (us_tick ? sub_q + 1'b1 : sub_q);
    assign inch_nxt  = (inch_tick && inch_q != INCH_MAX) ? inch_q + 1'b1 : inch_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        us_d    = us_q;
        sub_d   = sub_q;
        inch_d  = inch_q;
        dist_d  = dist_q;
        pulse_d = pulse_q;
        valid_d = 1'b0;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: if (!pw_s2_q) state_d = S_WAIT_RISE;
                S_WAIT_RISE: begin
                    if (pw_rise) begin
                        presc_d = '0;
                        us_d    = '0;
                        sub_d   = '0;
                        inch_d  = '0;
                        state_d = S_MEASURE;
                    end
                end
                default: begin
                    presc_d = presc_nxt;
                    us_d    = us_nxt;
                    sub_d   = sub_nxt;
                    inch_d  = inch_nxt;
                    // The fall cycle is counted too, so a pulse of N cycles yields N counts.
                    if (pw_fall) begin
                        dist_d  = inch_nxt;
                        pulse_d = us_nxt;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        tmo_d   = 1'b0;
                        state_d = S_WAIT_RISE;
                    end else if (us_nxt == US_MAX) begin
                        tmo_d   = 1'b1;
                        state_d = S_ARM;
                    end
                end
            endcase
        end
        rx_d   = (state_d != S_IDLE);
        busy_d = (state_d == S_MEASURE);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            pw_s1_q <= 1'b0;
            pw_s2_q <= 1'b0;
            pw_d_q  <= 1'b0;
            presc_q <= '0;
            us_q    <= '0;
            sub_q   <= '0;
            inch_q  <= '0;
            dist_q  <= '0;
            pulse_q <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            rx_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_s1_q <= pw_in;
            pw_s2_q <= pw_s1_q;
            pw_d_q  <= pw_s2_q;
            presc_q <= presc_d;
            us_q    <= us_d;
            sub_q   <= sub_d;
            inch_q  <= inch_d;
            dist_q  <= dist_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
        end
    end

    assign sonar_rx    = rx_q;
    assign distance_in = dist_q;
    assign pulse_us    = pulse_q;
    assign dist_valid  = valid_q;
    assign timeout     = tmo_q;
    assign busy        = busy_q;
    assign meas_count  = cnt_q;

endmodule
